cache_controller_nway: RTL and testbench
========================================

CACHE_CONTROLLER_NWAY -- requirements
Module: cache_controller_nway

Interface
REQ-001 Parameter WAYS, default 2: number of ways; legal values 1, 2, 4.
REQ-002 Parameter LINE_WORDS, default 4: 16-bit words per line; legal values 2, 4, 8. OW = log2(LINE_WORDS)+1 (byte-offset width).
REQ-003 Parameter MEM_LAT, default 2: cycles from memory read issue to data valid; legal range 1..4.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port addr_in / data_in, input, 16 each: request address / write data.
REQ-007 Port rd_in / wr_in, input, 1 each: read / write request strobe, sampled only in IDLE.
REQ-008 Port cache_hit / cache_valid / cache_dirty, input, WAYS each: per-way tag match / valid / dirty from the arrays.
REQ-009 Port mem_stall, input, 1: memory busy; no memory op may be issued in a cycle where it is high.
REQ-010 Port addr_out / data_out, output, 16 each: latched request address / data.
REQ-011 Port cache_enable, output, WAYS: one-hot way enable (all-ones in COMPARE).
REQ-012 Port cache_offset / mem_offset, output, OW each: byte offset to arrays / memory.
REQ-013 Port comp, write, data_src, tag_src, output, 1 each: array compare, array write, fill-data select (1 = memory), tag select for write-back (1 = victim tag).
REQ-014 Port mem_rd / mem_wr, output, 1 each: memory read / write issue.
REQ-015 Port done / stall / hit / err, output, 1 each: request complete, busy, completion was a hit, error pulse.

Function
REQ-016 States SHALL be: IDLE, COMPARE, SELECT, WB, FILL, DONE.
REQ-017 IDLE: addr/data/op registers load every cycle. rd_in^wr_in -> COMPARE. rd_in&wr_in -> err=1 for one cycle, stay IDLE, request dropped.
REQ-018 COMPARE: comp=1, write=latched wr, cache_offset=addr_out[OW-1:0], stall=1. Any way with hit&valid -> done=1, hit=1, next IDLE; otherwise next SELECT.
REQ-019 SELECT: victim = lowest-index invalid way, else the way given by the round-robin pointer (log2(WAYS) bits). cache_enable = one-hot victim, held through DONE. Pointer increments modulo WAYS on every SELECT that finds all ways valid. Next state: WB if the victim is valid and dirty, else FILL.
REQ-020 WB: counter k = 0..LINE_WORDS-1; mem_wr=1, tag_src=1, cache_offset=mem_offset=2k. k advances only when mem_stall=0 (mem_wr=0 while stalled). Leaves for FILL after the k = LINE_WORDS-1 issue.
REQ-021 FILL: request counter r issues mem_rd with mem_offset=2r when mem_stall=0. Write counter w asserts write=1, comp=0, data_src=1, cache_offset=2w exactly MEM_LAT cycles after read r=w was issued (shift-register tracking; stalls delay only issue). Leaves for DONE after the w = LINE_WORDS-1 write.
REQ-022 DONE: comp=1, data_src=0, write=latched wr, cache_offset=addr_out[OW-1:0], done=1, hit=0; next IDLE.
REQ-023 stall SHALL be 1 in every state except IDLE.
REQ-024 Offsets SHALL be OW bits; no counter may wrap past LINE_WORDS-1.
REQ-025 An unreachable state encoding SHALL pulse err=1 and go to IDLE.
REQ-026 Latency with mem_stall=0, request sampled at cycle t: hit -> done at t+1; clean miss -> done at t+2+LINE_WORDS+MEM_LAT+1; dirty miss -> an additional LINE_WORDS cycles.

Reset
REQ-027 While rst=0: state IDLE, round-robin pointer 0, tracking shift register and counters 0, all registered outputs 0, addr_out=data_out=0. rst asserted mid-miss aborts immediately and issues no further mem_rd/mem_wr.

Verification (WAYS=2, LINE_WORDS=4, MEM_LAT=2)
V1 Read 0x1234, way1 hit&valid -> done=hit=1 at t+1, cache_enable=2'b11, cache_offset=3'b100.
V2 Write 0x0040, both ways invalid, clean miss -> victim way0, mem_rd at offsets 0,2,4,6 on t+3..t+6, cache writes t+5..t+8, done=1 hit=0 at t+9 with write=1.
V3 Two consecutive misses with both ways valid and clean -> victims way0 then way1, pointer returns to 0 on the third.
V4 Dirty victim -> mem_wr with tag_src=1 at offsets 0,2,4,6 on t+3..t+6, then fill; done at t+13.
V5 mem_stall high for 3 cycles during FILL -> issue pauses, cache writes still land MEM_LAT after each issue, done delayed by exactly 3.
V6 rd_in=wr_in=1 in IDLE -> err pulse, no transition; rst low during WB -> outputs 0 in the same cycle, IDLE after release.

Source files
------------

// File: rtl/cache_controller_nway.sv
// N-way cache miss controller: tag compare, victim selection, dirty write-back and line fill.
// Memory ops pace themselves on mem_stall; fill data lands MEM_LAT cycles after each read issue.
module cache_controller_nway #(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int MEM_LAT    = 2,
    localparam int OW        = $clog2(LINE_WORDS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     addr_in,
    input  logic [15:0]     data_in,
    input  logic            rd_in,
    input  logic            wr_in,
    input  logic [WAYS-1:0] cache_hit,
    input  logic [WAYS-1:0] cache_valid,
    input  logic [WAYS-1:0] cache_dirty,
    input  logic            mem_stall,
    output logic [15:0]     addr_out,
    output logic [15:0]     data_out,
    output logic [WAYS-1:0] cache_enable,
    output logic [OW-1:0]   cache_offset,
    output logic [OW-1:0]   mem_offset,
    output logic            comp,
    output logic            write,
    output logic            data_src,
    output logic            tag_src,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            done,
    output logic            stall,
    output logic            hit,
    output logic            err
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

    // IDLE latch request | COMPARE tag check | SELECT pick victim | WB write back | FILL refill | DONE finish
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPARE = 3'd1;
    localparam logic [2:0] S_SELECT  = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state, state_nxt;
    logic               op_wr;
    logic [PW-1:0]      rr_ptr, vic_idx;
    logic               vic_found;
    logic [WAYS-1:0]    vic_oh, vic_q;
    logic [CW-1:0]      wb_cnt, wr_cnt;
    logic [CW:0]        rd_cnt;
    logic [MEM_LAT-1:0] lat_pipe;
    logic               any_hit, all_valid, vic_dirty;
    logic               wb_issue, rd_issue, fill_wr;

    assign any_hit   = |(cache_hit & cache_valid);
    assign all_valid = &cache_valid;

    always_comb begin
        vic_idx   = rr_ptr;
        vic_found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!cache_valid[i] && !vic_found) begin
                vic_idx   = PW'(i);
                vic_found = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            vic_oh[i] = (vic_idx == PW'(i));
        end
    end

    assign vic_dirty = cache_valid[vic_idx] & cache_dirty[vic_idx];
    assign wb_issue  = (state == S_WB) && !mem_stall;
    assign rd_issue  = (state == S_FILL) && !mem_stall && (rd_cnt < (CW+1)'(LINE_WORDS));
    // Each set bit is an outstanding read; the top bit marks data arriving this cycle.
    assign fill_wr   = (state == S_FILL) && lat_pipe[MEM_LAT-1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (rd_in ^ wr_in) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = any_hit ? S_IDLE : S_SELECT;
            S_SELECT:  state_nxt = vic_dirty ? S_WB : S_FILL;
            S_WB:      if (wb_issue && wb_cnt == CW'(LINE_WORDS - 1)) state_nxt = S_FILL;
            S_FILL:    if (fill_wr && wr_cnt == CW'(LINE_WORDS - 1)) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cache_enable = '0;
        cache_offset = '0;
        mem_offset   = '0;
        comp         = 1'b0;
        write        = 1'b0;
        data_src     = 1'b0;
        tag_src      = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        done         = 1'b0;
        hit          = 1'b0;
        err          = 1'b0;
        stall        = (state != S_IDLE);
        case (state)
            S_IDLE: err = rd_in & wr_in;
            S_COMPARE: begin
                comp         = 1'b1;
                write        = op_wr;
                cache_offset = addr_out[OW-1:0];
                cache_enable = '1;
                done         = any_hit;
                hit          = any_hit;
            end
            S_SELECT: cache_enable = vic_oh;
            S_WB: begin
                cache_enable = vic_q;
                tag_src      = 1'b1;
                mem_wr       = wb_issue;
                cache_offset = {wb_cnt, 1'b0};
                mem_offset   = {wb_cnt, 1'b0};
            end
            S_FILL: begin
                cache_enable = vic_q;
                data_src     = 1'b1;
                mem_rd       = rd_issue;
                mem_offset   = {rd_cnt[CW-1:0], 1'b0};
                write        = fill_wr;
                cache_offset = {wr_cnt, 1'b0};
            end
            S_DONE: begin
                comp         = 1'b1;
                write        = op_wr;
                cache_offset = addr_out[OW-1:0];
                cache_enable = vic_q;
                done         = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_out <= '0;
            data_out <= '0;
            op_wr    <= 1'b0;
            rr_ptr   <= '0;
            vic_q    <= '0;
            wb_cnt   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            lat_pipe <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                addr_out <= addr_in;
                data_out <= data_in;
                op_wr    <= wr_in;
            end
            if (state == S_SELECT) begin
                vic_q  <= vic_oh;
                wb_cnt <= '0;
                rd_cnt <= '0;
                wr_cnt <= '0;
                if (all_valid) rr_ptr <= (rr_ptr == PW'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
            end
            if (wb_issue) wb_cnt <= (wb_cnt == CW'(LINE_WORDS - 1)) ? '0 : wb_cnt + 1'b1;
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (fill_wr)  wr_cnt <= (wr_cnt == CW'(LINE_WORDS - 1)) ? '0 : wr_cnt + 1'b1;
            lat_pipe <= (state == S_FILL) ? ((lat_pipe << 1) | MEM_LAT'(rd_issue)) : '0;
        end
    end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Scoreboard bench for cache_controller_nway: a transaction-level model predicts every memory
// op, fill write, completion and error pulse; a negedge monitor pops and compares them.
module tb_cache_controller_nway;

    localparam int WAYS = 2;
    localparam int LW   = 4;
    localparam int ML   = 2;
    localparam int OW   = 3;

    localparam int KWR   = 0;
    localparam int KRD   = 1;
    localparam int KCW   = 2;
    localparam int KDONE = 3;
    localparam int KERR  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     addr_in, data_in;
    logic            rd_in, wr_in;
    logic [WAYS-1:0] cache_hit, cache_valid, cache_dirty;
    logic            mem_stall;
    logic [15:0]     addr_out, data_out;
    logic [WAYS-1:0] cache_enable;
    logic [OW-1:0]   cache_offset, mem_offset;
    logic            comp, write, data_src, tag_src, mem_rd, mem_wr;
    logic            done, stall, hit, err;

    cache_controller_nway #(.WAYS(WAYS), .LINE_WORDS(LW), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .rd_in(rd_in), .wr_in(wr_in), .cache_hit(cache_hit), .cache_valid(cache_valid),
        .cache_dirty(cache_dirty), .mem_stall(mem_stall), .addr_out(addr_out),
        .data_out(data_out), .cache_enable(cache_enable), .cache_offset(cache_offset),
        .mem_offset(mem_offset), .comp(comp), .write(write), .data_src(data_src),
        .tag_src(tag_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .done(done),
        .stall(stall), .hit(hit), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          off;
        int          hit;
        int          en;
        int          wflag;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  model_rr = 0;
    int  busy_from = 1;
    int  busy_to = 0;
    int  st_from = 0;
    int  st_len = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit stall_at(input int c);
        return (c >= st_from) && (c < st_from + st_len);
    endfunction

    task automatic push_ev(input int c, input int kind, input int off, input int h, input int en,
                           input int w, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.cyc = c; e.kind = kind; e.off = off; e.hit = h; e.en = en; e.wflag = w;
        e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Transaction-level prediction: latency, victim choice and memory timeline from the rules.
    task automatic model_req(input int t, input logic [15:0] a, input logic [15:0] d, input bit op,
                             input logic [1:0] hv, input logic [1:0] vv, input logic [1:0] dv,
                             output int dn);
        int v, en, c, k, r, fs;
        int it[LW];
        if ((hv & vv) != 2'b00) begin
            push_ev(t + 1, KDONE, int'(a[2:0]), 1, (1 << WAYS) - 1, int'(op), a, d);
            dn = t + 1;
            return;
        end
        v = -1;
        for (int i = 0; i < WAYS; i++) if (!vv[i] && v < 0) v = i;
        if (v < 0) begin
            v = model_rr;
            model_rr = (model_rr + 1) % WAYS;
        end
        en = 1 << v;
        c = t + 3;
        if (vv[v] && dv[v]) begin
            k = 0;
            while (k < LW) begin
                if (!stall_at(c)) begin
                    push_ev(c, KWR, 2 * k, 0, en, 0, a, d);
                    k++;
                end
                c++;
            end
        end
        fs = c;
        r = 0;
        while (r < LW) begin
            if (!stall_at(c)) begin
                it[r] = c;
                r++;
            end
            c++;
        end
        dn = it[LW-1] + ML + 1;
        for (int cc = fs; cc < dn; cc++) begin
            for (int i = 0; i < LW; i++) if (it[i] == cc) push_ev(cc, KRD, 2 * i, 0, en, 0, a, d);
            for (int i = 0; i < LW; i++) if (it[i] + ML == cc) push_ev(cc, KCW, 2 * i, 0, en, 1, a, d);
        end
        push_ev(dn, KDONE, int'(a[2:0]), 0, en, int'(op), a, d);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
            return;
        end
        failures = failures;
        e = exp_q.pop_front();
        checks--;
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        case (kind)
            KWR: begin
                chk("wb_mem_offset", mem_offset, e.off);
                chk("wb_cache_offset", cache_offset, e.off);
                chk("wb_tag_src", tag_src, 1);
                chk("wb_enable", cache_enable, e.en);
            end
            KRD: begin
                chk("rd_mem_offset", mem_offset, e.off);
                chk("rd_enable", cache_enable, e.en);
            end
            KCW: begin
                chk("fill_cache_offset", cache_offset, e.off);
                chk("fill_data_src", data_src, 1);
                chk("fill_enable", cache_enable, e.en);
            end
            KDONE: begin
                chk("done_hit", hit, e.hit);
                chk("done_enable", cache_enable, e.en);
                chk("done_offset", cache_offset, e.off);
                chk("done_write", write, e.wflag);
                chk("done_comp", comp, 1);
                chk("done_data_src", data_src, 0);
                chk("done_addr_out", addr_out, e.addr);
                chk("done_data_out", data_out, e.data);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall", stall, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
            if (mem_wr) pop_cmp(KWR);
            if (mem_rd) pop_cmp(KRD);
            if (write && !comp) pop_cmp(KCW);
            if (done) pop_cmp(KDONE);
            if (err) pop_cmp(KERR);
        end
    end

    task automatic run_req(input logic [15:0] a, input logic [15:0] d, input bit op,
                           input logic [1:0] hv, input logic [1:0] vv, input logic [1:0] dv,
                           input int s_rel, input int s_len, input int abort_rel);
        int t, dn;
        @(posedge clk); #1;
        t = cyc;
        st_from = t + s_rel;
        st_len = s_len;
        addr_in = a; data_in = d; rd_in = ~op; wr_in = op;
        cache_hit = hv; cache_valid = vv; cache_dirty = dv;
        mem_stall = stall_at(t);
        model_req(t, a, d, op, hv, vv, dv, dn);
        busy_from = t + 1;
        busy_to = dn;
        while (cyc <= dn) begin
            @(posedge clk); #1;
            rd_in = 1'b0; wr_in = 1'b0;
            addr_in = 16'($urandom); data_in = 16'($urandom);
            mem_stall = stall_at(cyc);
            if (abort_rel > 0 && cyc == t + abort_rel) begin
                chk("pre_reset_mem_wr", mem_wr, 1);
                mon_en = 1'b0;
                rst = 1'b0;
                #1;
                chk("reset_mem_wr_now", mem_wr, 0);
                chk("reset_stall_now", stall, 0);
                chk("reset_tag_src_now", tag_src, 0);
                chk("reset_enable_now", cache_enable, 0);
                chk("reset_addr_out_now", addr_out, 0);
                chk("reset_data_out_now", data_out, 0);
                exp_q.delete();
                model_rr = 0;
                busy_from = 1; busy_to = 0; st_len = 0; mem_stall = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("reset_hold_mem_rd", mem_rd, 0);
                    chk("reset_hold_mem_wr", mem_wr, 0);
                end
                @(posedge clk); #1;
                rst = 1'b1;
                mon_en = 1'b1;
                return;
            end
        end
        mem_stall = 1'b0;
    endtask

    task automatic run_err();
        int t;
        @(posedge clk); #1;
        t = cyc;
        rd_in = 1'b1; wr_in = 1'b1;
        push_ev(t, KERR, 0, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk); #1;
        rd_in = 1'b0; wr_in = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        addr_in = 16'hA5A5; data_in = 16'h5A5A;
        rd_in = 1'b0; wr_in = 1'b0;
        cache_hit = '0; cache_valid = '0; cache_dirty = '0;
        mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr_out", addr_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_enable", cache_enable, 0);
        chk("rst_mem_ops", {mem_rd, mem_wr}, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        run_req(16'h1234, 16'h1111, 1'b0, 2'b10, 2'b10, 2'b00, 0, 0, 0);
        run_req(16'h0040, 16'hBEEF, 1'b1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        repeat (3) run_req(16'h0102, 16'h2222, 1'b0, 2'b00, 2'b11, 2'b00, 0, 0, 0);
        run_req(16'h0207, 16'h3333, 1'b0, 2'b00, 2'b11, 2'b11, 0, 0, 0);
        run_req(16'h0305, 16'h4444, 1'b1, 2'b00, 2'b01, 2'b00, 4, 3, 0);
        run_req(16'h0406, 16'h5555, 1'b1, 2'b01, 2'b11, 2'b11, 4, 2, 0);
        run_err();
        run_req(16'h0ABC, 16'h6666, 1'b0, 2'b00, 2'b11, 2'b11, 0, 0, 4);
        run_req(16'h0ACE, 16'h7777, 1'b1, 2'b00, 2'b11, 2'b11, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] hv, vv, dv;
            vv = 2'($urandom);
            dv = 2'($urandom);
            hv = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            run_req(16'($urandom), 16'($urandom), 1'($urandom), hv, vv, dv,
                    $urandom_range(1, 12), $urandom_range(0, 4), 0);
            if ($urandom_range(0, 9) == 0) run_err();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
